mem_port_arbiter: RTL

Two-master arbiter in front of main-memory port A (14-bit word address, 18-bit data, one-cycle registered read). Master 0 is the CPU load/store path; master 1 is the serial loader/DMA path. Each cycle the block selects at most one master, drives the port-A address/write-enable/data, and returns read data to the originating master one cycle later. A lock handshake keeps a master's ownership for read-modify-write sequences, and a watchdog bounds how long a lock may be held.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter_watchdog.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the port-A memory arbiter: default widths, FSM states, master id.
package mem_port_arbiter_pkg;

  localparam int DATA_W       = 18;
  localparam int ADDR_W       = 14;
  localparam int MAX_LOCK_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  typedef logic mst_id_t;

  function automatic arb_state_e own_state(input mst_id_t id);
    return id ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Lock watchdog: counts cycles of held ownership and forces release at MAX_LOCK.
module mem_lock_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic       clka,
  input  logic       rst,
  input  logic       owned,
  input  logic       unlock,
  input  mst_id_t    owner,
  output logic       expire,
  output logic [1:0] evicted
);

  localparam int CW = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    evicted_q, evicted_d;

  // A voluntary release on the last allowed cycle is not an eviction.
  always_comb begin
    expire    = owned && !unlock && (cnt_q == CW'(MAX_LOCK - 1));
    cnt_d     = (owned && !unlock && !expire) ? cnt_q + 1'b1 : '0;
    evicted_d = '0;
    if (expire) evicted_d[owner] = 1'b1;
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      cnt_q     <= '0;
      evicted_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      evicted_q <= evicted_d;
    end
  end

  assign evicted = evicted_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for memory port A with lock/watchdog and one-cycle read return.
// MEM_ARB_ROUNDROBIN_EN selects round-robin conflict resolution; otherwise master 0 wins.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA     = DATA_W,
  parameter int ADDR     = ADDR_W,
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic            clka,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic            m0_lock,
  input  logic [ADDR-1:0] m0_addr,
  input  logic [DATA-1:0] m0_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DATA-1:0] m0_rdata,
  output logic            m0_evicted,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic            m1_lock,
  input  logic [ADDR-1:0] m1_addr,
  input  logic [DATA-1:0] m1_wdata,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DATA-1:0] m1_rdata,
  output logic            m1_evicted,
  output logic            mem_we,
  output logic [ADDR-1:0] mem_addr,
  output logic [DATA-1:0] mem_din,
  input  logic [DATA-1:0] mem_dout
);

  logic [1:0]           req, we, lock, gnt, rv, evicted_q;
  logic [1:0][ADDR-1:0] addr;
  logic [1:0][DATA-1:0] wdata;
  logic                 any_gnt, owned, unlock, expire;
  mst_id_t              win, owner;

  arb_state_e           state_q, state_d;
  logic [ADDR-1:0]      addr_q, addr_d;
  logic [DATA-1:0]      din_q, din_d;
  logic                 rd_vld_q, rd_vld_d;
  mst_id_t              rd_id_q, rd_id_d;
  logic [1:0][DATA-1:0] rdata_q, rdata_d;
`ifdef MEM_ARB_ROUNDROBIN_EN
  mst_id_t              last_q, last_d;
`endif

  assign req   = {m1_req, m0_req};
  assign we    = {m1_we, m0_we};
  assign lock  = {m1_lock, m0_lock};
  assign addr  = {m1_addr, m0_addr};
  assign wdata = {m1_wdata, m0_wdata};

  always_comb begin
    owned  = (state_q != IDLE);
    owner  = mst_id_t'(state_q == OWN1);
    unlock = !lock[owner];
  end

  // The master that was not just evicted gets first claim on the post-eviction cycle.
  always_comb begin
    win = 1'b0;
    gnt = '0;
    case (state_q)
      IDLE: begin
        if (evicted_q[0] && req[1])      win = 1'b1;
        else if (evicted_q[1] && req[0]) win = 1'b0;
`ifdef MEM_ARB_ROUNDROBIN_EN
        else if (&req)                   win = ~last_q;
`else
        else if (&req)                   win = 1'b0;
`endif
        else                             win = ~req[0];
        gnt[win] = |req;
      end
      default: begin
        win      = owner;
        gnt[win] = req[win];
      end
    endcase
    if (rst) gnt = '0;
    any_gnt = |gnt;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (any_gnt && lock[win]) state_d = own_state(win);
      OWN0, OWN1: if (unlock || expire)     state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d   = any_gnt ? addr[win]  : addr_q;
    din_d    = any_gnt ? wdata[win] : din_q;
    rd_vld_d = any_gnt && !we[win];
    rd_id_d  = win;
    rv[0]    = rd_vld_q && !rd_id_q && !rst;
    rv[1]    = rd_vld_q &&  rd_id_q && !rst;
    rdata_d  = rdata_q;
    for (int n = 0; n < 2; n++)
      if (rv[n]) rdata_d[n] = mem_dout;
`ifdef MEM_ARB_ROUNDROBIN_EN
    last_d   = any_gnt ? win : last_q;
`endif
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      din_q    <= '0;
      rd_vld_q <= 1'b0;
      rd_id_q  <= 1'b0;
      rdata_q  <= '0;
`ifdef MEM_ARB_ROUNDROBIN_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rd_vld_q <= rd_vld_d;
      rd_id_q  <= rd_id_d;
      rdata_q  <= rdata_d;
`ifdef MEM_ARB_ROUNDROBIN_EN
      last_q   <= last_d;
`endif
    end
  end

  mem_lock_watchdog #(.MAX_LOCK(MAX_LOCK)) u_wdog (
    .clka    (clka),
    .rst     (rst),
    .owned   (owned),
    .unlock  (unlock),
    .owner   (owner),
    .expire  (expire),
    .evicted (evicted_q)
  );

  assign m0_gnt     = gnt[0];
  assign m1_gnt     = gnt[1];
  assign m0_rvalid  = rv[0];
  assign m1_rvalid  = rv[1];
  assign m0_rdata   = rdata_d[0];
  assign m1_rdata   = rdata_d[1];
  assign m0_evicted = evicted_q[0] && !rst;
  assign m1_evicted = evicted_q[1] && !rst;
  assign mem_we     = any_gnt && we[win];
  assign mem_addr   = addr_d;
  assign mem_din    = din_d;

endmodule
